// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit paths.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small first-word fall-through FIFO holding received characters.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
// A pop and a push in the same cycle both take effect, even when the FIFO is full.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wrPtr_q;
    logic [AW:0]      rdPtr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             doPush;
    logic             doPop;

    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign doPop   = pop_i && !empty_o;
    assign doPush  = push_i && (!full_o || doPop);
    assign data_o  = empty_o ? '0 : mem_q[rdPtr_q[AW-1:0]];

    // Advance the read and write pointers on accepted pops and pushes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
        end
    end

    // Storage array; no reset needed because the head is masked while empty.
    always_ff @(posedge clk_i) begin
        if (doPush) mem_q[wrPtr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive path with a small FIFO toward the register logic.
// Optional macro UART_RX_PARITY_EN switches the frame to 8E1 and adds parity_err_o.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD_RATE   = 115200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      rx_i,
    input  logic                      rd_en_i,
    output logic [UART_DATA_BITS-1:0] rd_data_o,
    output logic                      rd_valid_o,
    output logic                      full_o,
    output logic                      busy_o,
    output logic                      frame_err_o,
    output logic                      overrun_o,
`ifdef UART_RX_PARITY_EN
    output logic                      parity_err_o,
`endif
    input  logic                      clr_err_i
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
`ifdef UART_RX_PARITY_EN
    localparam rx_state_t AFTER_DATA = PARITY;
`else
    localparam rx_state_t AFTER_DATA = STOP;
`endif

    logic                      rxMeta_q;
    logic                      rxSync_q;
    rx_state_t                 state_q;
    logic [CNT_W-1:0]          clkCnt_q;
    logic [2:0]                bitIdx_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic                      frameErr_q;
    logic                      overrun_q;
    logic                      parityDrop;
    logic                      fifoFull;
    logic                      fifoEmpty;
    logic                      stopSample;
    logic                      goodStop;
    logic                      pushEn;
    logic                      overrunEv;

`ifdef UART_RX_PARITY_EN
    logic parityBad_q;
    logic parityErr_q;
    assign parityDrop   = parityBad_q;
    assign parity_err_o = parityErr_q;
`else
    assign parityDrop = 1'b0;
`endif

    // A good stop bit pushes unless the FIFO is full with no pop freeing a slot.
    assign stopSample = (state_q == STOP) && (clkCnt_q == CNT_MAX);
    assign goodStop   = stopSample && rxSync_q && !parityDrop;
    assign pushEn     = goodStop && (!fifoFull || rd_en_i);
    assign overrunEv  = goodStop && fifoFull && !rd_en_i;

    assign busy_o      = (state_q != IDLE);
    assign frame_err_o = frameErr_q;
    assign overrun_o   = overrun_q;
    assign full_o      = fifoFull;
    assign rd_valid_o  = !fifoEmpty;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= rx_i;
            rxSync_q <= rxMeta_q;
        end
    end

    // Deframing FSM plus sticky error flags; a set event overrides a clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            clkCnt_q   <= '0;
            bitIdx_q   <= '0;
            shift_q    <= '0;
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityBad_q <= 1'b0;
            parityErr_q <= 1'b0;
`endif
        end else begin
            if (clr_err_i) begin
                frameErr_q <= 1'b0;
                overrun_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parityErr_q <= 1'b0;
`endif
            end
            case (state_q)
                IDLE: begin
                    if (!rxSync_q) begin
                        state_q  <= START;
                        clkCnt_q <= '0;
                    end
                end
                START: begin
                    if (clkCnt_q == HALF_M1) begin
                        clkCnt_q <= '0;
                        bitIdx_q <= '0;
                        state_q  <= rxSync_q ? IDLE : DATA;
                    end else begin
                        clkCnt_q <= clkCnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (clkCnt_q == CNT_MAX) begin
                        clkCnt_q <= '0;
                        shift_q  <= {rxSync_q, shift_q[UART_DATA_BITS-1:1]};
                        bitIdx_q <= bitIdx_q + 3'd1;
                        if (bitIdx_q == 3'd7) state_q <= AFTER_DATA;
                    end else begin
                        clkCnt_q <= clkCnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (clkCnt_q == CNT_MAX) begin
                        clkCnt_q    <= '0;
                        state_q     <= STOP;
                        parityBad_q <= (^shift_q) ^ rxSync_q;
                        if ((^shift_q) ^ rxSync_q) parityErr_q <= 1'b1;
                    end else begin
                        clkCnt_q <= clkCnt_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (clkCnt_q == CNT_MAX) begin
                        clkCnt_q <= '0;
                        if (rxSync_q) begin
                            state_q <= IDLE;
                            if (overrunEv) overrun_q <= 1'b1;
                        end else begin
                            state_q    <= BREAK;
                            frameErr_q <= 1'b1;
                        end
                    end else begin
                        clkCnt_q <= clkCnt_q + 1'b1;
                    end
                end
                BREAK: begin
                    if (rxSync_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (pushEn),
        .pop_i   (rd_en_i),
        .data_i  (shift_q),
        .data_o  (rd_data_o),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

endmodule
